// File: rtl/fb_pkg.sv
// Shared framebuffer definitions used by the read-side and write-side initiators.
// Holds the frame geometry, the memory word/pixel widths, the reader FSM state
// type and the rule that maps a pixel coordinate to an SDRAM word address.
package fb_pkg;

    localparam int unsigned H_ACTIVE = 320;  // pixels per line
    localparam int unsigned V_ACTIVE = 240;  // lines per frame
    localparam int unsigned X_W      = 9;    // column counter width
    localparam int unsigned Y_W      = 15;   // row counter width
    localparam int unsigned ADDR_W   = 24;   // memory word address width (X_W + Y_W)
    localparam int unsigned DATA_W   = 16;   // RGB565 pixel width

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_ADV,
        ST_FULLWAIT
    } rd_state_e;

    // Each row occupies a 2**X_W word stride, so the address is just {row, column}.
    function automatic logic [ADDR_W-1:0] fb_pack_addr(
        input logic [Y_W-1:0] cy,
        input logic [X_W-1:0] cx
    );
        return {cy, cx};
    endfunction

endpackage

// File: rtl/fb_sync_fifo.sv
// Single-clock show-ahead FIFO.
// Ports:
//   clk, rst_n  - clock, asynchronous active-low reset
//   flush       - empties the FIFO; wins over a same-cycle push/pop
//   push/push_data - write port; a push into a full FIFO is accepted only
//                  when a pop happens in the same cycle
//   pop         - removes the head entry; ignored when empty
//   head_data   - current head entry (zero when empty), no read latency
//   empty       - no entries stored
//   count       - number of stored entries (0 .. FIFO_DEPTH)
module fb_sync_fifo #(
    parameter int unsigned DATA_W     = 16,
    parameter int unsigned FIFO_DEPTH = 16
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         flush,
    input  logic                         push,
    input  logic [DATA_W-1:0]            push_data,
    input  logic                         pop,
    output logic [DATA_W-1:0]            head_data,
    output logic                         empty,
    output logic [$clog2(FIFO_DEPTH):0]  count
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);

    logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]    count_q, count_d;
    logic              is_empty, is_full;
    logic              do_push, do_pop, wr_en;

    assign is_empty = (count_q == '0);
    assign is_full  = (count_q == (PTR_W+1)'(FIFO_DEPTH));

    always_comb begin
        do_pop   = pop && !is_empty;
        do_push  = push && (!is_full || do_pop);
        wr_en    = do_push && !flush;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            // Power-of-two depth: pointers wrap by natural overflow.
            if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
            count_d = count_q + (PTR_W+1)'(do_push) - (PTR_W+1)'(do_pop);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: an entry is only visible after it has been written.
    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wr_ptr_q] <= push_data;
    end

    assign head_data = is_empty ? '0 : mem_q[rd_ptr_q];
    assign empty     = is_empty;
    assign count     = count_q;

endmodule

// File: rtl/fb_line_reader.sv
// Framebuffer read-side initiator.
// Walks the frame in raster order, issuing one single-word read per pixel on
// the controller's call/done read channel, and streams the returned pixels to
// the display pipeline through a show-ahead FIFO.
// Ports:
//   clk, rst_n   - clock, asynchronous active-low reset
//   frame_start  - one-cycle pulse restarting the walk at address 0
//   mem_call_rd  - read request, held with mem_addr until mem_done_rd
//   mem_done_rd  - one-cycle read completion, qualifies mem_rdata
//   mem_addr     - read word address {CY, CX}
//   mem_rdata    - read data
//   pix_valid / pix_data / pix_ready - pixel stream (head of FIFO)
//   frame_busy   - a frame walk is in progress
//   underflow    - sticky: consumer asked for a pixel while none was ready
module fb_line_reader #(
    parameter int unsigned H_ACTIVE   = fb_pkg::H_ACTIVE,
    parameter int unsigned V_ACTIVE   = fb_pkg::V_ACTIVE,
    parameter int unsigned X_W        = fb_pkg::X_W,
    parameter int unsigned Y_W        = fb_pkg::Y_W,
    parameter int unsigned ADDR_W     = fb_pkg::ADDR_W,
    parameter int unsigned DATA_W     = fb_pkg::DATA_W,
    parameter int unsigned FIFO_DEPTH = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              frame_start,
    output logic              mem_call_rd,
    input  logic              mem_done_rd,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              pix_valid,
    output logic [DATA_W-1:0] pix_data,
    input  logic              pix_ready,
    output logic              frame_busy,
    output logic              underflow
);

    import fb_pkg::*;

    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;

    rd_state_e        state_q, state_d;
    logic [X_W-1:0]   cx_q, cx_d;
    logic [Y_W-1:0]   cy_q, cy_d;
    logic             call_q, call_d;
    logic             busy_q, busy_d;
    logic             restart_pend_q, restart_pend_d;
    logic             underflow_q, underflow_d;

    logic             fifo_flush;
    logic             fifo_push;
    logic             fifo_empty;
    logic [CNT_W-1:0] fifo_count;
    logic             space_ok;
    logic             last_col, last_row;

    assign space_ok = (fifo_count < CNT_W'(FIFO_DEPTH));
    assign last_col = (cx_q == X_W'(H_ACTIVE - 1));
    assign last_row = (cy_q == Y_W'(V_ACTIVE - 1));

    always_comb begin
        state_d        = state_q;
        cx_d           = cx_q;
        cy_d           = cy_q;
        restart_pend_d = restart_pend_q;
        fifo_flush     = 1'b0;
        fifo_push      = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (frame_start) begin
                    cx_d       = '0;
                    cy_d       = '0;
                    fifo_flush = 1'b1;
                    state_d    = ST_REQ;
                end
            end
            ST_REQ: begin
                // The request is never withdrawn; a restart is deferred to ADV
                // and the data of the in-flight read is dropped.
                if (frame_start) restart_pend_d = 1'b1;
                if (mem_done_rd) begin
                    fifo_push = !(restart_pend_q || frame_start);
                    state_d   = ST_ADV;
                end
            end
            ST_ADV: begin
                if (frame_start || restart_pend_q) begin
                    // Flush leaves the FIFO empty, so the space check always passes.
                    restart_pend_d = 1'b0;
                    cx_d           = '0;
                    cy_d           = '0;
                    fifo_flush     = 1'b1;
                    state_d        = ST_REQ;
                end else if (last_col && last_row) begin
                    state_d = ST_IDLE;
                end else begin
                    if (last_col) begin
                        cx_d = '0;
                        cy_d = cy_q + 1'b1;
                    end else begin
                        cx_d = cx_q + 1'b1;
                    end
                    state_d = space_ok ? ST_REQ : ST_FULLWAIT;
                end
            end
            ST_FULLWAIT: begin
                if (frame_start) begin
                    cx_d       = '0;
                    cy_d       = '0;
                    fifo_flush = 1'b1;
                    state_d    = ST_REQ;
                end else if (space_ok) begin
                    state_d = ST_REQ;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        call_d      = (state_d == ST_REQ);
        busy_d      = (state_d != ST_IDLE);
        underflow_d = frame_start ? 1'b0 : (underflow_q || (pix_ready && fifo_empty));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= ST_IDLE;
            cx_q           <= '0;
            cy_q           <= '0;
            call_q         <= 1'b0;
            busy_q         <= 1'b0;
            restart_pend_q <= 1'b0;
            underflow_q    <= 1'b0;
        end else begin
            state_q        <= state_d;
            cx_q           <= cx_d;
            cy_q           <= cy_d;
            call_q         <= call_d;
            busy_q         <= busy_d;
            restart_pend_q <= restart_pend_d;
            underflow_q    <= underflow_d;
        end
    end

    fb_sync_fifo #(
        .DATA_W     (DATA_W),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (fifo_flush),
        .push      (fifo_push),
        .push_data (mem_rdata),
        .pop       (pix_ready),
        .head_data (pix_data),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    assign mem_call_rd = call_q;
    assign mem_addr    = fb_pack_addr(cy_q, cx_q);
    assign pix_valid   = !fifo_empty;
    assign frame_busy  = busy_q;
    assign underflow   = underflow_q;

endmodule

// File: tb/tb_fb_line_reader.sv
module tb_fb_line_reader;

    localparam int H = 320;
    localparam int V = 3;    // short frame keeps a full walk within a few thousand cycles

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        frame_start = 1'b0;
    logic        mem_call_rd;
    logic        mem_done_rd = 1'b0;
    logic [23:0] mem_addr;
    logic [15:0] mem_rdata = 16'h0000;
    logic        pix_valid;
    logic [15:0] pix_data;
    logic        pix_ready = 1'b0;
    logic        frame_busy;
    logic        underflow;

    int tests_run = 0;
    int tests_failed = 0;
    int viol = 0;
    int lat = 0;

    logic [23:0] req_q[$];
    logic [15:0] pix_q[$];
    logic        prev_call = 1'b0;
    logic        prev_done = 1'b0;
    logic [23:0] prev_addr = '0;

    fb_line_reader #(.V_ACTIVE(V)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .frame_start (frame_start),
        .mem_call_rd (mem_call_rd),
        .mem_done_rd (mem_done_rd),
        .mem_addr    (mem_addr),
        .mem_rdata   (mem_rdata),
        .pix_valid   (pix_valid),
        .pix_data    (pix_data),
        .pix_ready   (pix_ready),
        .frame_busy  (frame_busy),
        .underflow   (underflow)
    );

    always #5 clk = ~clk;

    // Controller model: done three cycles after call, data = addr[15:0].
    always @(posedge clk) begin
        #1;
        if (!rst_n) begin
            mem_done_rd = 1'b0;
            lat = 0;
        end else if (mem_done_rd) begin
            mem_done_rd = 1'b0;
            mem_rdata = 16'hDEAD;
            lat = 0;
        end else if (mem_call_rd) begin
            lat++;
            if (lat == 3) begin
                mem_done_rd = 1'b1;
                mem_rdata = mem_addr[15:0];
            end
        end
    end

    // Request/pixel recorder and handshake rule tracker.
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_call = 1'b0;
            prev_done = 1'b0;
            prev_addr = '0;
        end else begin
            if (mem_call_rd && !prev_call) req_q.push_back(mem_addr);
            if (prev_done && mem_call_rd) viol++;
            if (prev_call && !prev_done && (!mem_call_rd || mem_addr != prev_addr)) viol++;
            if (mem_done_rd && !mem_call_rd) viol++;
            if (pix_valid && pix_ready) pix_q.push_back(pix_data);
            prev_call = mem_call_rd;
            prev_done = mem_done_rd;
            prev_addr = mem_addr;
        end
    end

    function automatic logic [23:0] exp_addr(input int i);
        logic [23:0] a;
        a = '0;
        a[23:9] = 15'(i / H);
        a[8:0]  = 9'(i % H);
        return a;
    endfunction

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        pix_ready = 1'b0;
        frame_start = 1'b0;
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        step();
        req_q.delete();
        pix_q.delete();
    endtask

    task automatic pulse_frame_start();
        frame_start = 1'b1;
        step();
        frame_start = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        step();
        step();
        tests_run++; if (mem_call_rd !== 1'b0) begin tests_failed++; $display("FAIL reset_call: got %b expected 0", mem_call_rd); end
        tests_run++; if (mem_addr !== 24'h000000) begin tests_failed++; $display("FAIL reset_addr: got %h expected 000000", mem_addr); end
        tests_run++; if (pix_valid !== 1'b0 || pix_data !== 16'h0000) begin tests_failed++; $display("FAIL reset_pix: got valid=%b data=%h expected 0/0000", pix_valid, pix_data); end
        tests_run++; if (frame_busy !== 1'b0 || underflow !== 1'b0) begin tests_failed++; $display("FAIL reset_flags: got busy=%b underflow=%b expected 0/0", frame_busy, underflow); end
        rst_n = 1'b1;
        step();
        tests_run++; if (mem_call_rd !== 1'b0 || frame_busy !== 1'b0) begin tests_failed++; $display("FAIL idle_after_reset: got call=%b busy=%b expected 0/0", mem_call_rd, frame_busy); end
    endtask

    task automatic test_full_frame();
        int cyc;
        int bad;
        logic [23:0] ea;
        req_q.delete();
        pix_q.delete();
        pix_ready = 1'b1;
        pulse_frame_start();
        tests_run++; if (frame_busy !== 1'b1 || mem_call_rd !== 1'b1 || mem_addr !== 24'h0) begin tests_failed++; $display("FAIL frame_first_req: got busy=%b call=%b addr=%h expected 1/1/000000", frame_busy, mem_call_rd, mem_addr); end
        cyc = 0;
        while (frame_busy === 1'b1 && cyc < 10000) begin step(); cyc++; end
        tests_run++; if (frame_busy !== 1'b0) begin tests_failed++; $display("FAIL frame_end: got busy=%b after %0d cycles expected 0", frame_busy, cyc); end
        repeat (3) step();
        tests_run++; if (req_q.size() != H * V) begin tests_failed++; $display("FAIL frame_req_count: got %0d expected %0d", req_q.size(), H * V); end
        bad = -1;
        for (int i = 0; i < req_q.size(); i++) if (bad < 0 && req_q[i] !== exp_addr(i)) bad = i;
        tests_run++; if (bad >= 0) begin tests_failed++; $display("FAIL frame_addr_seq: index %0d got %h expected %h", bad, req_q[bad], exp_addr(bad)); end
        tests_run++; if (req_q.size() <= 320 || req_q[319] !== 24'h00013F || req_q[320] !== 24'h000200) begin tests_failed++; $display("FAIL frame_row_wrap: got size=%0d expected 0x13F then 0x200", req_q.size()); end
        tests_run++; if (pix_q.size() != H * V) begin tests_failed++; $display("FAIL frame_pix_count: got %0d expected %0d", pix_q.size(), H * V); end
        bad = -1;
        for (int i = 0; i < pix_q.size(); i++) begin
            ea = exp_addr(i);
            if (bad < 0 && pix_q[i] !== ea[15:0]) bad = i;
        end
        tests_run++; if (bad >= 0) begin tests_failed++; $display("FAIL frame_pix_seq: index %0d got %h", bad, pix_q[bad]); end
        tests_run++; if (mem_call_rd !== 1'b0 || pix_valid !== 1'b0) begin tests_failed++; $display("FAIL frame_idle: got call=%b valid=%b expected 0/0", mem_call_rd, pix_valid); end
        pix_ready = 1'b0;
    endtask

    task automatic test_fifo_full();
        int cyc;
        int bad;
        pix_ready = 1'b0;
        req_q.delete();
        pix_q.delete();
        pulse_frame_start();
        repeat (100) step();
        tests_run++; if (req_q.size() != 16) begin tests_failed++; $display("FAIL full_req_count: got %0d expected 16", req_q.size()); end
        tests_run++; if (mem_call_rd !== 1'b0 || pix_valid !== 1'b1 || pix_data !== 16'h0000) begin tests_failed++; $display("FAIL full_state: got call=%b valid=%b head=%h expected 0/1/0000", mem_call_rd, pix_valid, pix_data); end
        repeat (20) step();
        tests_run++; if (req_q.size() != 16 || mem_call_rd !== 1'b0) begin tests_failed++; $display("FAIL fullwait_hold: got reqs=%0d call=%b expected 16/0", req_q.size(), mem_call_rd); end
        pix_ready = 1'b1;
        step();
        pix_ready = 1'b0;
        tests_run++; if (pix_data !== 16'h0001) begin tests_failed++; $display("FAIL pop_head: got %h expected 0001", pix_data); end
        cyc = 0;
        while (mem_done_rd !== 1'b1 && cyc < 20) begin step(); cyc++; end
        tests_run++; if (mem_done_rd !== 1'b1) begin tests_failed++; $display("FAIL refill_done: got %b expected 1", mem_done_rd); end
        // pop in the same cycle the refill data is pushed
        pix_ready = 1'b1;
        step();
        pix_ready = 1'b0;
        tests_run++; if (req_q.size() != 17 || req_q[16] !== 24'h000010) begin tests_failed++; $display("FAIL refill_req: got reqs=%0d expected 17 with last 000010", req_q.size()); end
        tests_run++; if (pix_valid !== 1'b1 || pix_data !== 16'h0002) begin tests_failed++; $display("FAIL push_pop_head: got valid=%b head=%h expected 1/0002", pix_valid, pix_data); end
        repeat (10) step();
        tests_run++; if (req_q.size() != 18 || mem_call_rd !== 1'b0) begin tests_failed++; $display("FAIL refull: got reqs=%0d call=%b expected 18/0", req_q.size(), mem_call_rd); end
        pix_ready = 1'b1;
        repeat (40) step();
        pix_ready = 1'b0;
        step();
        bad = -1;
        for (int i = 0; i < pix_q.size(); i++) if (bad < 0 && pix_q[i] !== 16'(i)) bad = i;
        tests_run++; if (bad >= 0 || pix_q.size() < 18) begin tests_failed++; $display("FAIL fifo_order: got size=%0d first bad index %0d expected contiguous from 0", pix_q.size(), bad); end
    endtask

    task automatic test_restart_req();
        int cyc;
        do_reset();
        pix_ready = 1'b1;
        pulse_frame_start();
        cyc = 0;
        while (!(mem_call_rd === 1'b1 && mem_addr === 24'h000105 && mem_done_rd === 1'b0) && cyc < 3000) begin step(); cyc++; end
        tests_run++; if (mem_call_rd !== 1'b1 || mem_addr !== 24'h000105) begin tests_failed++; $display("FAIL restart_reach: got call=%b addr=%h expected 1/000105", mem_call_rd, mem_addr); end
        frame_start = 1'b1;
        pix_ready = 1'b0;
        step();
        frame_start = 1'b0;
        tests_run++; if (mem_call_rd !== 1'b1 || mem_addr !== 24'h000105) begin tests_failed++; $display("FAIL restart_call_held: got call=%b addr=%h expected 1/000105", mem_call_rd, mem_addr); end
        cyc = 0;
        while (mem_call_rd === 1'b1 && cyc < 20) begin step(); cyc++; end
        tests_run++; if (mem_call_rd !== 1'b0 || pix_valid !== 1'b0) begin tests_failed++; $display("FAIL restart_drop: got call=%b valid=%b expected 0/0", mem_call_rd, pix_valid); end
        cyc = 0;
        while (mem_call_rd !== 1'b1 && cyc < 20) begin step(); cyc++; end
        tests_run++; if (mem_call_rd !== 1'b1 || mem_addr !== 24'h000000 || pix_valid !== 1'b0) begin tests_failed++; $display("FAIL restart_next: got call=%b addr=%h valid=%b expected 1/000000/0", mem_call_rd, mem_addr, pix_valid); end
        tests_run++; if (pix_q.size() != 261) begin tests_failed++; $display("FAIL restart_pix_count: got %0d expected 261", pix_q.size()); end
        pix_ready = 1'b1;
        repeat (8) step();
        pix_ready = 1'b0;
        tests_run++; if (pix_q.size() < 262 || pix_q[261] !== 16'h0000) begin tests_failed++; $display("FAIL restart_first_pixel: got size=%0d expected pixel 0000 at index 261", pix_q.size()); end
    endtask

    task automatic test_underflow();
        do_reset();
        tests_run++; if (underflow !== 1'b0) begin tests_failed++; $display("FAIL underflow_clear: got %b expected 0", underflow); end
        pix_ready = 1'b1;
        step();
        pix_ready = 1'b0;
        tests_run++; if (underflow !== 1'b1 || pix_valid !== 1'b0) begin tests_failed++; $display("FAIL underflow_set: got uf=%b valid=%b expected 1/0", underflow, pix_valid); end
        repeat (5) step();
        tests_run++; if (underflow !== 1'b1) begin tests_failed++; $display("FAIL underflow_sticky: got %b expected 1", underflow); end
        pulse_frame_start();
        tests_run++; if (underflow !== 1'b0) begin tests_failed++; $display("FAIL underflow_cleared: got %b expected 0", underflow); end
    endtask

    task automatic test_handshake();
        tests_run++; if (viol != 0) begin tests_failed++; $display("FAIL handshake_rules: got %0d violations expected 0", viol); end
    endtask

    task automatic test_async_reset();
        int cyc;
        pix_ready = 1'b1;
        cyc = 0;
        while (mem_call_rd !== 1'b1 && cyc < 100) begin step(); cyc++; end
        tests_run++; if (mem_call_rd !== 1'b1) begin tests_failed++; $display("FAIL areset_setup: got call=%b expected 1", mem_call_rd); end
        #1;
        rst_n = 1'b0;
        #1;
        tests_run++; if (mem_call_rd !== 1'b0 || mem_addr !== 24'h0) begin tests_failed++; $display("FAIL areset_call: got call=%b addr=%h expected 0/000000", mem_call_rd, mem_addr); end
        tests_run++; if (pix_valid !== 1'b0 || pix_data !== 16'h0 || frame_busy !== 1'b0 || underflow !== 1'b0) begin tests_failed++; $display("FAIL areset_outputs: got valid=%b data=%h busy=%b uf=%b expected all 0", pix_valid, pix_data, frame_busy, underflow); end
        pix_ready = 1'b0;
        step();
        rst_n = 1'b1;
        step();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_full_frame();
        test_fifo_full();
        test_restart_req();
        test_underflow();
        test_handshake();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
